mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock, results registered on the final step.
module mul_div_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mr_out,
    output logic [WIDTH-1:0] dr_out,
    output logic             dz
);

    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    // hi/lo hold {product high, multiplier/low} or {remainder, quotient}.
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_d, mr_d, dr_d;
    logic               dz_d, busy_d, done_d;

    logic [WIDTH-1:0]   hi_step_c, lo_step_c;
    logic [WIDTH:0]     sum_c, shifted_c, diff_c;

    // One iteration of the selected algorithm on the current datapath.
    always_comb begin
        sum_c     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted_c = {hi_q, lo_q[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, opnd_q};
        hi_step_c = hi_q;
        lo_step_c = lo_q;
        if (op_q) begin
            // Borrow clear means the shifted remainder covered the divisor.
            if (!diff_c[WIDTH]) begin
                hi_step_c = diff_c[WIDTH-1:0];
                lo_step_c = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step_c = shifted_c[WIDTH-1:0];
                lo_step_c = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step_c = sum_c[WIDTH:1];
            lo_step_c = {sum_c[0], lo_q[WIDTH-1:1]};
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        acc_d   = acc_out;
        mr_d    = mr_out;
        dr_d    = dr_out;
        dz_d    = dz;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op && (b_in == '0)) begin
                        state_d = DONE;
                        acc_d   = '1;
                        dr_d    = a_in;
                        mr_d    = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        op_d    = op;
                        cnt_d   = CNT_W'(STEPS);
                        hi_d    = '0;
                        lo_d    = op ? a_in : b_in;
                        opnd_d  = op ? b_in : a_in;
                    end
                end
            end
            RUN: begin
                hi_d  = hi_step_c;
                lo_d  = lo_step_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    acc_d   = lo_step_c;
                    dz_d    = 1'b0;
                    if (op_q) dr_d = hi_step_c;
                    else      mr_d = hi_step_c;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            acc_out <= '0;
            mr_out  <= '0;
            dr_out  <= '0;
            dz      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            acc_out <= acc_d;
            mr_out  <= mr_d;
            dr_out  <= dr_d;
            dz      <= dz_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products, quotients,
// latency, divide-by-zero, ignored starts and mid-run reset.
module tb_mul_div_unit;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] acc_out;
    logic [W-1:0] mr_out;
    logic [W-1:0] dr_out;
    logic         dz;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    int busy_cnt;
    int done_cnt;

    mul_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .acc_out (acc_out),
        .mr_out  (mr_out),
        .dr_out  (dr_out),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; optionally keep
    // hammering start with other operands while the unit is running.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output int c, output int bc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        c  = 1;
        bc = 0;
        while (!done && c < 40) begin
            if (busy) bc++;
            if (noise) begin
                start = 1'b1;
                op    = c[0];
                a_in  = W'(c * 7 + 3);
                b_in  = W'(c + 1);
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] acc, input logic [W-1:0] mr,
                              input logic [W-1:0] dr, input logic z);
        check({tag, "_acc"}, 32'(acc_out), 32'(acc));
        check({tag, "_mr"},  32'(mr_out),  32'(mr));
        check({tag, "_dr"},  32'(dr_out),  32'(dr));
        check({tag, "_dz"},  32'(dz),      32'(z));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a_in  = 16'h0005;
        b_in  = 16'h0005;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_outs("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst   = 1'b0;
        start = 1'b0;

        // Multiply latency and result
        run_op(1'b0, 16'h1234, 16'h0100, 1'b0, cyc, busy_cnt);
        check("mul1_latency", 32'(cyc), 32'd17);
        check("mul1_busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul1_done", 32'(done), 32'd1);
        check("mul1_busy_in_done", 32'(busy), 32'd0);
        check_outs("mul1", 16'h3400, 16'h0012, 16'h0000, 1'b0);
        @(negedge clk);
        check("mul1_done_pulse", 32'(done), 32'd0);

        // Divide 100 / 7, mr_out keeps previous product high half
        run_op(1'b1, 16'd100, 16'd7, 1'b0, cyc, busy_cnt);
        check("div1_latency", 32'(cyc), 32'd17);
        check_outs("div1", 16'h000E, 16'h0012, 16'h0002, 1'b0);

        // Full-scale multiply, dr_out keeps previous remainder
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, cyc, busy_cnt);
        check_outs("mul2", 16'h0001, 16'hFFFE, 16'h0002, 1'b0);

        // Dividend smaller than divisor
        run_op(1'b1, 16'h0005, 16'h0009, 1'b0, cyc, busy_cnt);
        check_outs("div2", 16'h0000, 16'hFFFE, 16'h0005, 1'b0);

        // Divide by zero completes immediately
        run_op(1'b1, 16'h00AB, 16'h0000, 1'b0, cyc, busy_cnt);
        check("dz_latency", 32'(cyc), 32'd1);
        check("dz_busy_cycles", 32'(busy_cnt), 32'd0);
        check_outs("dz", 16'hFFFF, 16'h0000, 16'h00AB, 1'b1);
        @(negedge clk);
        check("dz_done_pulse", 32'(done), 32'd0);

        // Starts during RUN/DONE are ignored
        run_op(1'b0, 16'h0013, 16'h0011, 1'b1, cyc, busy_cnt);
        check("noise_latency", 32'(cyc), 32'd17);
        check_outs("noise", 16'h0143, 16'h0000, 16'h00AB, 1'b0);
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("noise_extra_done", 32'(done_cnt), 32'd0);
        check("noise_hold_acc", 32'(acc_out), 32'h0143);

        // Reset on the 8th RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_in  = 16'hFFFF;
        b_in  = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_outs("abort", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // First start after reset is accepted
        run_op(1'b0, 16'd3, 16'd5, 1'b0, cyc, busy_cnt);
        check("post_rst_latency", 32'(cyc), 32'd17);
        check_outs("post_rst", 16'h000F, 16'h0000, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
